// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: byte stream -> big-endian 32-bit words, holds the CPU in reset until loaded.
// Optional trailer checksum enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              restart,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              error
);

  localparam int unsigned IDX_W = ADDR_W + 1;
  localparam int unsigned CAP   = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_HDR0, S_HDR1, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state, state_n;
  logic [1:0]        byte_cnt, byte_cnt_n;
  logic [IDX_W-1:0]  word_idx, word_idx_n;
  logic [15:0]       count, count_n;
  logic [23:0]       word, word_n;
  logic              ready_q, ready_n;
  logic              mem_we_n, cpu_hold_n, done_n, error_n;
  logic [ADDR_W-1:0] mem_addr_n;
  logic [31:0]       mem_wdata_n;
  logic [15:0]       hdr_count;
  logic              accept;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]        xor_acc, xor_n;
`endif

  assign accept    = in_valid && in_ready;
  assign hdr_count = {count[15:8], in_data};
  // Ready is a registered flag, but must drop immediately while reset is asserted
  assign in_ready  = ready_q && !rst;

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_HDR0;
      byte_cnt  <= 2'd0;
      word_idx  <= '0;
      count     <= 16'd0;
      word      <= 24'd0;
      ready_q   <= 1'b1;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'd0;
      cpu_hold  <= 1'b1;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_acc   <= 8'd0;
`endif
    end else begin
      state     <= state_n;
      byte_cnt  <= byte_cnt_n;
      word_idx  <= word_idx_n;
      count     <= count_n;
      word      <= word_n;
      ready_q   <= ready_n;
      mem_we    <= mem_we_n;
      mem_addr  <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      cpu_hold  <= cpu_hold_n;
      done      <= done_n;
      error     <= error_n;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_acc   <= xor_n;
`endif
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_n     = state;
    byte_cnt_n  = byte_cnt;
    word_idx_n  = word_idx;
    count_n     = count;
    word_n      = word;
    mem_we_n    = 1'b0;
    mem_addr_n  = mem_addr;
    mem_wdata_n = mem_wdata;
    cpu_hold_n  = cpu_hold;
    done_n      = done;
    error_n     = error;
`ifdef IMEM_LOADER_CHECKSUM_EN
    xor_n       = xor_acc;
`endif

    if (restart) begin
      state_n    = S_HDR0;
      byte_cnt_n = 2'd0;
      word_idx_n = '0;
      count_n    = 16'd0;
      cpu_hold_n = 1'b1;
      done_n     = 1'b0;
      error_n    = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      xor_n      = 8'd0;
`endif
    end else if (accept) begin
      case (state)
        S_HDR0: begin
          count_n = {in_data, 8'd0};
          state_n = S_HDR1;
        end
        S_HDR1: begin
          count_n = hdr_count;
          if (32'(hdr_count) > CAP) begin
            state_n = S_ERROR;
            error_n = 1'b1;
          end else if (hdr_count == 16'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_n = S_CHECK;
`else
            state_n    = S_DONE;
            done_n     = 1'b1;
            cpu_hold_n = 1'b0;
`endif
          end else begin
            state_n = S_DATA;
          end
        end
        S_DATA: begin
          word_n     = {word[15:0], in_data};
          byte_cnt_n = byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          xor_n      = xor_acc ^ in_data;
`endif
          if (byte_cnt == 2'd3) begin
            mem_we_n    = 1'b1;
            mem_addr_n  = word_idx[ADDR_W-1:0];
            mem_wdata_n = {word, in_data};
            word_idx_n  = word_idx + IDX_W'(1);
            if (32'(word_idx) + 32'd1 == 32'(count)) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
              state_n = S_CHECK;
`else
              state_n    = S_DONE;
              done_n     = 1'b1;
              cpu_hold_n = 1'b0;
`endif
            end
          end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (in_data == xor_acc) begin
            state_n    = S_DONE;
            done_n     = 1'b1;
            cpu_hold_n = 1'b0;
          end else begin
            state_n = S_ERROR;
            error_n = 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end

    ready_n = (state_n != S_DONE) && (state_n != S_ERROR);
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: expected writes queued by stimulus, checked by a write monitor.
// Adapts stream trailers to IMEM_LOADER_CHECKSUM_EN.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        restart;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold, done, error;

  logic [7:0]  s_data;
  logic        s_valid, s_ready, s_restart, s_we, s_hold, s_done, s_error;
  logic [1:0]  s_addr;
  logic [31:0] s_wdata;

  int tests = 0;
  int fails = 0;

  typedef struct packed { logic [7:0] addr; logic [31:0] data; } wr_t;
  wr_t exp_q[$];

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .restart(restart), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  imem_loader #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst(rst), .in_data(s_data), .in_valid(s_valid), .in_ready(s_ready),
    .restart(s_restart), .mem_we(s_we), .mem_addr(s_addr), .mem_wdata(s_wdata),
    .cpu_hold(s_hold), .done(s_done), .error(s_error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Write monitor: every mem_we pulse must match the head of the expected queue
  always @(negedge clk) begin
    if (!rst && mem_we) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write: got %h@%h expected no write", mem_wdata, mem_addr);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          fails++;
          $display("FAIL write: got %h@%h expected %h@%h", mem_wdata, mem_addr, e.data, e.addr);
        end
      end
    end
    if (!rst && s_we) begin
      tests++;
      fails++;
      $display("FAIL small_write: got %h@%h expected no write", s_wdata, s_addr);
    end
  end

  task automatic send(input logic [7:0] b);
    int guard = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!in_ready) begin
      tests++; fails++;
      $display("FAIL ready_timeout: got in_ready=0 expected 1 within 100 cycles");
    end
    @(posedge clk); #1;
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
    in_valid = 1'b0;
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    @(posedge clk); #1;
    restart = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] a, input logic [31:0] d);
    wr_t w;
    w.addr = a;
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic check_drained(input string name);
    idle(2);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_done(input string name);
    check({name, "_done"}, 32'(done), 32'd1);
    check({name, "_hold"}, 32'(cpu_hold), 32'd0);
    check({name, "_ready"}, 32'(in_ready), 32'd0);
    check({name, "_error"}, 32'(error), 32'd0);
  endtask

  initial begin
    logic [7:0] stream[$];
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; restart = 1'b0;
    s_data = 8'h00; s_valid = 1'b0; s_restart = 1'b0;
    #2;
    check("rst_ready", 32'(in_ready), 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    check("rst_we", 32'(mem_we), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", mem_wdata, 32'd0);
    idle(2);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 32'(in_ready), 32'd1);

    // Three-word back-to-back load
    push(8'd0, 32'h201000E8); push(8'd1, 32'h20080005); push(8'd2, 32'h20090007);
    stream = '{8'h00, 8'h03, 8'h20, 8'h10, 8'h00, 8'hE8, 8'h20, 8'h08, 8'h00, 8'h05,
               8'h20, 8'h09, 8'h00, 8'h07};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'hDB);
`endif
    send_list(stream);
    check_done("three");
    check_drained("three_drained");

    pulse_restart();
    check("restart_done", 32'(done), 32'd0);
    check("restart_hold", 32'(cpu_hold), 32'd1);
    check("restart_ready", 32'(in_ready), 32'd1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Same image with a bad checksum trailer
    push(8'd0, 32'h201000E8); push(8'd1, 32'h20080005); push(8'd2, 32'h20090007);
    stream = '{8'h00, 8'h03, 8'h20, 8'h10, 8'h00, 8'hE8, 8'h20, 8'h08, 8'h00, 8'h05,
               8'h20, 8'h09, 8'h00, 8'h07, 8'hDA};
    send_list(stream);
    check("badcs_error", 32'(error), 32'd1);
    check("badcs_done", 32'(done), 32'd0);
    check("badcs_hold", 32'(cpu_hold), 32'd1);
    check("badcs_ready", 32'(in_ready), 32'd0);
    check_drained("badcs_drained");
    pulse_restart();
`endif

    // Stall mid-word
    push(8'd0, 32'h8FB00000);
    stream = '{8'h00, 8'h01, 8'h8F};
    send_list(stream);
    idle(10);
    check("stall_no_write", 32'(exp_q.size()), 32'd1);
    check("stall_ready", 32'(in_ready), 32'd1);
    stream = '{8'hB0, 8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h3F);
`endif
    send_list(stream);
    check_done("stall");
    check_drained("stall_drained");

    // Restart after two payload bytes, then a clean one-word load
    pulse_restart();
    stream = '{8'h00, 8'h01, 8'h08, 8'h00};
    send_list(stream);
    pulse_restart();
    push(8'd0, 32'h08000010);
    stream = '{8'h00, 8'h01, 8'h08, 8'h00, 8'h00, 8'h10};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h18);
`endif
    send_list(stream);
    check_done("abort");
    check_drained("abort_drained");

    // Empty image
    pulse_restart();
    stream = '{8'h00, 8'h00};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h00);
`endif
    send_list(stream);
    check_done("empty");

    // Asynchronous reset mid-word, checked before any clock edge
    pulse_restart();
    stream = '{8'h00, 8'h01, 8'hAA, 8'hBB};
    send_list(stream);
    #2 rst = 1'b1;
    #1;
    check("arst_ready", 32'(in_ready), 32'd0);
    check("arst_we", 32'(mem_we), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_error", 32'(error), 32'd0);
    check("arst_hold", 32'(cpu_hold), 32'd1);
    idle(2);
    rst = 1'b0;
    #1;
    push(8'd0, 32'h12345678);
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'h08);
`endif
    send_list(stream);
    check_done("fresh");
    check_drained("fresh_drained");

    // Capacity boundary on a 4-word memory
    s_valid = 1'b1; s_data = 8'h00;
    @(posedge clk); #1;
    s_data = 8'h05;
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("over_error", 32'(s_error), 32'd1);
    check("over_ready", 32'(s_ready), 32'd0);
    check("over_hold", 32'(s_hold), 32'd1);
    check("over_done", 32'(s_done), 32'd0);
    s_restart = 1'b1;
    @(posedge clk); #1;
    s_restart = 1'b0;
    check("over_restart_error", 32'(s_error), 32'd0);
    s_valid = 1'b1; s_data = 8'h00;
    @(posedge clk); #1;
    s_data = 8'h04;
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("cap_error", 32'(s_error), 32'd0);
    check("cap_ready", 32'(s_ready), 32'd1);
    idle(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
